// File: rtl/usb_bus_state.sv
// USB line-state monitor: synchronizes and glitch-filters D+/D-, then tracks
// ACTIVE / SUSPEND / RESUME / BUS_RESET from long J and SE0 runs.
module usb_bus_state #(
    parameter int FILTER_CYCLES  = 3,
    parameter int SUSPEND_CYCLES = 144000,
    parameter int RESET_CYCLES   = 12000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic [1:0] line_state,
    output logic       bus_reset,
    output logic       suspend,
    output logic       resume,
    output logic [1:0] state
);

    localparam int JW = $clog2(SUSPEND_CYCLES + 1);
    localparam int SW = $clog2(RESET_CYCLES + 1);
    localparam logic [JW-1:0] J_LIMIT   = JW'(SUSPEND_CYCLES);
    localparam logic [SW-1:0] SE0_LIMIT = SW'(RESET_CYCLES);
    localparam logic [3:0]    FILT_LIM  = 4'(FILTER_CYCLES);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;

    localparam logic [1:0] ST_ACTIVE    = 2'd0;
    localparam logic [1:0] ST_SUSPEND   = 2'd1;
    localparam logic [1:0] ST_RESUME    = 2'd2;
    localparam logic [1:0] ST_BUS_RESET = 2'd3;

    logic [1:0]    sync1, sync2, cand;
    logic [3:0]    filt_cnt, filt_next;
    logic [JW-1:0] j_cnt, j_next;
    logic [SW-1:0] se0_cnt, se0_next;
    logic          j_reach, se0_reach;
    logic [1:0]    state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {usb_p_rx, usb_n_rx};
            sync2 <= sync1;
        end
    end

    // filt_cnt counts consecutive samples equal to cand that differ from line_state
    always_comb begin
        filt_next = 4'd1;
        if (sync2 == cand && filt_cnt != 4'd0)
            filt_next = filt_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand       <= 2'b00;
            filt_cnt   <= 4'd0;
            line_state <= LS_SE0;
        end else begin
            cand <= sync2;
            if (sync2 == line_state) begin
                filt_cnt <= 4'd0;
            end else if (filt_next == FILT_LIM) begin
                line_state <= sync2;
                filt_cnt   <= 4'd0;
            end else begin
                filt_cnt <= filt_next;
            end
        end
    end

    always_comb begin
        j_next = '0;
        if (line_state == LS_J)
            j_next = (j_cnt == J_LIMIT) ? j_cnt : j_cnt + JW'(1);
        se0_next = '0;
        if (line_state == LS_SE0)
            se0_next = (se0_cnt == SE0_LIMIT) ? se0_cnt : se0_cnt + SW'(1);
        j_reach   = (j_cnt != J_LIMIT) && (j_next == J_LIMIT);
        se0_reach = (se0_cnt != SE0_LIMIT) && (se0_next == SE0_LIMIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACTIVE:    if (j_reach) state_next = ST_SUSPEND;
            ST_SUSPEND:   if (line_state == LS_K) state_next = ST_RESUME;
            ST_RESUME:    if (line_state == LS_J || line_state == LS_SE0) state_next = ST_ACTIVE;
            ST_BUS_RESET: if (line_state != LS_SE0) state_next = ST_ACTIVE;
            default:      state_next = ST_ACTIVE;
        endcase
        // Extended SE0 overrides whatever else would happen this cycle
        if (se0_reach)
            state_next = ST_BUS_RESET;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            j_cnt     <= '0;
            se0_cnt   <= '0;
            state     <= ST_ACTIVE;
            bus_reset <= 1'b0;
            suspend   <= 1'b0;
            resume    <= 1'b0;
        end else begin
            j_cnt     <= j_next;
            se0_cnt   <= se0_next;
            state     <= state_next;
            bus_reset <= (state_next == ST_BUS_RESET);
            suspend   <= (state_next == ST_SUSPEND);
            resume    <= (state == ST_SUSPEND) && (state_next == ST_RESUME);
        end
    end

endmodule

// File: tb/tb_usb_bus_state.sv
// Bench for usb_bus_state: directed timing checks plus randomized line activity
// compared every cycle against a run-length based reference model.
module tb_usb_bus_state;

    localparam int F = 3;
    localparam int S = 100;
    localparam int R = 50;
    localparam logic [1:0] SE0 = 2'b00, K = 2'b01, J = 2'b10, SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       usb_p_rx = 1'b0;
    logic       usb_n_rx = 1'b0;
    logic [1:0] line_state, state;
    logic       bus_reset, suspend, resume;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_bus_state #(.FILTER_CYCLES(F), .SUSPEND_CYCLES(S), .RESET_CYCLES(R)) dut (
        .clk(clk), .reset_n(reset_n), .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
        .line_state(line_state), .bus_reset(bus_reset), .suspend(suspend),
        .resume(resume), .state(state)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pins reach the filter two edges late; line_state takes a
    // value once the last F synchronized samples all agree on something new.
    int m_s1 = 0, m_s2 = 0, m_ls = 0, m_jrun = 0, m_serun = 0, m_state = 0;
    int m_resume = 0;
    int hist[$];
    int ls_old, st_old, nxt;
    bit same;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_ls = 0; m_jrun = 0; m_serun = 0;
            m_state = 0; m_resume = 0;
            hist.delete();
            for (int i = 0; i < F; i++) hist.push_back(0);
        end else begin
            ls_old = m_ls;
            st_old = m_state;
            m_jrun  = (ls_old == 2) ? m_jrun + 1 : 0;
            m_serun = (ls_old == 0) ? m_serun + 1 : 0;
            nxt = st_old;
            case (st_old)
                0: if (m_jrun == S) nxt = 1;
                1: if (ls_old == 1) nxt = 2;
                2: if (ls_old == 2 || ls_old == 0) nxt = 0;
                default: if (ls_old != 0) nxt = 0;
            endcase
            if (m_serun == R) nxt = 3;
            m_resume = (st_old == 1 && nxt == 2) ? 1 : 0;
            m_state  = nxt;
            hist.push_back(m_s2);
            void'(hist.pop_front());
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same && hist[0] != ls_old) m_ls = hist[0];
            m_s2 = m_s1;
            m_s1 = {usb_p_rx, usb_n_rx};
        end
    end

    always @(negedge clk) begin
        chk("line_state", line_state, m_ls);
        chk("state", state, m_state);
        chk("suspend", suspend, (m_state == 1) ? 1 : 0);
        chk("bus_reset", bus_reset, (m_state == 3) ? 1 : 0);
        chk("resume", resume, m_resume);
    end

    // Called just after a negedge; returns after n further posedges.
    task automatic drive(input logic [1:0] v, input int n);
        #1 {usb_p_rx, usb_n_rx} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ls"}, line_state, 0);
        chk({name, "_state"}, state, 0);
        chk({name, "_bus_reset"}, bus_reset, 0);
        chk({name, "_suspend"}, suspend, 0);
        chk({name, "_resume"}, resume, 0);
    endtask

    logic [1:0] v;
    int n, r;

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        #2 reset_n = 1'b1;
        @(negedge clk);

        // SE0 -> J step: visible exactly 5 edges later
        drive(J, 4);
        chk("latency_4", line_state, 0);
        @(negedge clk);
        chk("latency_5", line_state, 2);
        drive(K, 2);
        drive(J, 10);
        chk("k_glitch", line_state, 2);
        // J run is at 12 here; suspend on count 100
        repeat (87) @(negedge clk);
        chk("suspend_99", suspend, 0);
        @(negedge clk);
        chk("suspend_100", suspend, 1);
        chk("suspend_state", state, 1);

        // Resume: K 20, SE0 2 (filtered), then J
        #1 {usb_p_rx, usb_n_rx} = K;
        repeat (5) @(negedge clk);
        chk("pre_resume_state", state, 1);
        @(negedge clk);
        chk("resume_pulse", resume, 1);
        chk("resume_state", state, 2);
        @(negedge clk);
        chk("resume_single", resume, 0);
        chk("resume_hold", state, 2);
        repeat (13) @(negedge clk);
        drive(SE0, 2);
        drive(J, 6);
        chk("resume_eop_state", state, 0);
        chk("resume_eop_suspend", suspend, 0);
        chk("resume_eop_ls", line_state, 2);

        // 99 J cycles then an SE0 blip: no suspend
        drive(SE0, 1);
        do_reset();
        drive(J, 99);
        drive(SE0, 4);
        drive(J, 60);
        chk("no_suspend_99", suspend, 0);
        chk("no_suspend_state", state, 0);

        // Extended SE0 from ACTIVE
        drive(SE0, 54);
        chk("bus_reset_54", bus_reset, 0);
        @(negedge clk);
        chk("bus_reset_55", bus_reset, 1);
        chk("bus_reset_state", state, 3);
        drive(J, 5);
        chk("bus_reset_hold", bus_reset, 1);
        @(negedge clk);
        chk("bus_reset_release", bus_reset, 0);
        chk("release_state", state, 0);

        // Extended SE0 from SUSPEND
        drive(J, 100);
        chk("suspend_again", state, 1);
        drive(SE0, 55);
        chk("reset_from_suspend", state, 3);
        chk("reset_from_suspend_bus", bus_reset, 1);
        chk("reset_from_suspend_susp", suspend, 0);

        // reset_n pulse during BUS_RESET, J held across release
        #2 reset_n = 1'b0;
        {usb_p_rx, usb_n_rx} = J;
        repeat (2) @(negedge clk);
        chk_all_zero("rst_in_busreset");
        #2 reset_n = 1'b1;
        repeat (104) @(negedge clk);
        chk("restart_104", suspend, 0);
        @(negedge clk);
        chk("restart_105", suspend, 1);

        // reset_n pulse at J count 80
        drive(SE0, 1);
        do_reset();
        drive(J, 85);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("rst_at_j80");
        #2 reset_n = 1'b1;
        repeat (104) @(negedge clk);
        chk("j80_restart_104", suspend, 0);
        @(negedge clk);
        chk("j80_restart_105", suspend, 1);

        // Randomized line activity
        for (int seg = 0; seg < 400; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      begin v = J;   n = $urandom_range(1, 140); end
            else if (r < 55) begin v = K;   n = $urandom_range(1, 30);  end
            else if (r < 75) begin v = SE0; n = $urandom_range(1, 70);  end
            else if (r < 82) begin v = SE1; n = $urandom_range(1, 8);   end
            else if (r < 98) begin v = 2'($urandom_range(0, 3)); n = $urandom_range(1, 3); end
            else begin v = 2'b00; n = 0; end
            if (n == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
                @(negedge clk);
            end else begin
                drive(v, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_bus_state.md
USB_BUS_STATE -- requirements
Module: usb_bus_state

Interface
REQ-001 Parameter FILTER_CYCLES, default 3: consecutive identical synchronized samples required to accept a new line state (1..15).
REQ-002 Parameter SUSPEND_CYCLES, default 144000: consecutive filtered-J cycles that signal suspend (3 ms at 48 MHz).
REQ-003 Parameter RESET_CYCLES, default 12000: consecutive filtered-SE0 cycles that signal bus reset.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 usb_p_rx  input  1  raw D+ receiver, asynchronous to clk.
REQ-007 usb_n_rx  input  1  raw D- receiver, asynchronous to clk.
REQ-008 line_state  output  2  filtered {D+,D-}: 2'b10 J, 2'b01 K, 2'b00 SE0, 2'b11 SE1.
REQ-009 bus_reset  output  1  level, high while extended SE0 persists.
REQ-010 suspend  output  1  level, high while in SUSPEND state.
REQ-011 resume  output  1  single-cycle pulse on SUSPEND->RESUME transition.
REQ-012 state  output  2  FSM state: 0 ACTIVE, 1 SUSPEND, 2 RESUME, 3 BUS_RESET.

Function
REQ-013 Each pin SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 line_state SHALL update to the synchronized pair only after that pair has differed from line_state and held one value for FILTER_CYCLES consecutive cycles; any change restarts the count.
REQ-015 Pin-to-line_state latency SHALL be exactly 2+FILTER_CYCLES clk edges for a clean step; pulses shorter than FILTER_CYCLES cycles SHALL never appear on line_state.
REQ-016 J counter: increments each cycle line_state==J, clears on any other value, saturates at SUSPEND_CYCLES.
REQ-017 SE0 counter: increments each cycle line_state==SE0, clears on any other value, saturates at RESET_CYCLES.
REQ-018 Counter widths SHALL be ceil(log2(N+1)) of their limit; no wrap-around at any count.
REQ-019 ACTIVE -> SUSPEND on the edge the J counter reaches SUSPEND_CYCLES.
REQ-020 SUSPEND -> RESUME on the first cycle line_state==K; resume high for exactly that one cycle.
REQ-021 RESUME holds while line_state==K; -> ACTIVE when line_state becomes J or SE0 (resume EOP).
REQ-022 Any state -> BUS_RESET on the edge the SE0 counter reaches RESET_CYCLES; BUS_RESET takes priority over every other transition in the same cycle.
REQ-023 BUS_RESET -> ACTIVE on the first cycle line_state!=SE0; J counter restarts from 0.
REQ-024 bus_reset==1 iff state==BUS_RESET; suspend==1 iff state==SUSPEND; both registered, glitch-free.
REQ-025 SE1 SHALL clear both counters and cause no state transition.
REQ-026 Short SE0 (EOP, <RESET_CYCLES) in ACTIVE SHALL only clear the J counter.

Reset
REQ-027 While reset_n low: synchronizers 0, filter count 0, line_state 2'b00, both counters 0, state ACTIVE, bus_reset/suspend/resume 0.
REQ-028 Deassertion of reset_n mid-sequence SHALL restart all counting from these values; no event is carried across reset.

Verification (FILTER_CYCLES=3, SUSPEND_CYCLES=100, RESET_CYCLES=50)
REQ-029 Pins step SE0->J -> line_state==2'b10 exactly 5 edges later; 2-cycle K glitch within J -> line_state stays 2'b10.
REQ-030 J held 100 cycles after filtering -> suspend rises on count 100, state 1; 99 cycles then 1 K-free SE0 blip (>=3 cycles) -> no suspend.
REQ-031 In SUSPEND drive K 20 cycles then SE0 2 cycles, J -> resume pulse 1 cycle, state 2, then state 0, suspend 0.
REQ-032 SE0 held 50 filtered cycles from ACTIVE and from SUSPEND -> bus_reset 1, state 3; release to J -> bus_reset 0 next cycle, state 0.
REQ-033 SE0 reaching 50 on same edge as a pending SUSPEND/RESUME transition -> state 3 wins.
REQ-034 reset_n pulsed low during BUS_RESET and during J count 80 -> all outputs 0, J count restarts, suspend only after 100 further J cycles.
